// File: rtl/lc3b_types.sv
// Shared LC-3b types: data word, memory-op opcodes and the MEM-stage FSM states.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [3:0]  lc3b_opcode;

    localparam lc3b_opcode op_ldr  = 4'b0110;
    localparam lc3b_opcode op_ldb  = 4'b0010;
    localparam lc3b_opcode op_ldi  = 4'b1010;
    localparam lc3b_opcode op_str  = 4'b0111;
    localparam lc3b_opcode op_stb  = 4'b0011;
    localparam lc3b_opcode op_sti  = 4'b1011;
    localparam lc3b_opcode op_trap = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        IND_GAP,
        IND_ACCESS
    } mem_state_t;

endpackage

// File: rtl/mem_lane_steer.sv
// Byte-lane steering: write enables and replicated write data for STB, sign-extended LDB data.
module mem_lane_steer
    import lc3b_types::*;
(
    input  logic       byte_op,
    input  logic       addr_lsb,
    input  lc3b_word   sr,
    input  lc3b_word   rdata,
    output logic [1:0] byte_enable,
    output lc3b_word   wdata,
    output lc3b_word   byte_sext
);

    logic [7:0] rbyte;

    always_comb begin
        if (byte_op) begin
            byte_enable = addr_lsb ? 2'b10 : 2'b01;
            wdata       = {sr[7:0], sr[7:0]};
        end else begin
            byte_enable = 2'b11;
            wdata       = sr;
        end
        rbyte     = addr_lsb ? rdata[15:8] : rdata[7:0];
        byte_sext = {{8{rbyte[7]}}, rbyte};
    end

endmodule

// File: rtl/register.sv
// Generic loadable register with synchronous active-high clear.
module register #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
        end else if (load) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// LC-3b MEM stage: direct and indirect data accesses, upstream stall, MEM/WB latch.
module mem_access_stage #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned IND_GAP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_alu,
    input  logic [WIDTH-1:0] in_sr,
    input  logic [WIDTH-1:0] in_ir,
    input  logic [WIDTH-1:0] in_pc,
    output logic             stall,
    output logic [WIDTH-1:0] mem_address,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       mem_byte_enable,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_resp,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_alu,
    output logic [WIDTH-1:0] out_mdr,
    output logic [WIDTH-1:0] out_ir,
    output logic [WIDTH-1:0] out_pc
);
    import lc3b_types::*;

    mem_state_t state_q, state_d;
    lc3b_word   ptr_q, ptr_d;
    lc3b_word   addr;
    lc3b_word   byte_sext;
    lc3b_word   mdr_d;
    lc3b_opcode opcode;
    logic       is_load, is_store, is_ind, mem_op;
    logic [63:0] latch_d, latch_q;

    assign opcode   = in_ir[15:12];
    assign is_load  = opcode inside {op_ldr, op_ldb, op_ldi, op_trap};
    assign is_store = opcode inside {op_str, op_stb, op_sti};
    assign is_ind   = (opcode == op_ldi) || (opcode == op_sti);
    assign mem_op   = in_valid && (is_load || is_store);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        addr      = in_alu;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        stall     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (is_ind) begin
                        // First indirect access always fetches the pointer.
                        mem_read = 1'b1;
                        stall    = 1'b1;
                        if (mem_resp) begin
                            ptr_d   = mem_rdata;
                            state_d = (IND_GAP != 0) ? lc3b_types::IND_GAP : IND_ACCESS;
                        end
                    end else begin
                        mem_read  = is_load;
                        mem_write = is_store;
                        stall     = !mem_resp;
                    end
                end
            end
            lc3b_types::IND_GAP: begin
                stall   = 1'b1;
                state_d = IND_ACCESS;
            end
            IND_ACCESS: begin
                addr      = ptr_q;
                mem_read  = (opcode == op_ldi);
                mem_write = (opcode == op_sti);
                stall     = !mem_resp;
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_address = addr & 16'hFFFE;

    mem_lane_steer u_lane_steer (
        .byte_op     (opcode == op_stb || opcode == op_ldb),
        .addr_lsb    (in_alu[0]),
        .sr          (in_sr),
        .rdata       (mem_rdata),
        .byte_enable (mem_byte_enable),
        .wdata       (mem_wdata),
        .byte_sext   (byte_sext)
    );

    always_comb begin
        mdr_d = '0;
        if (in_valid && is_load) begin
            mdr_d = (opcode == op_ldb) ? byte_sext : mem_rdata;
        end
    end

    assign latch_d = {in_alu, mdr_d, in_ir, in_pc};

    // Valid reloads every cycle so a stall inserts a bubble while the payload holds.
    register #(.WIDTH(1)) u_valid_reg (
        .clk   (clk),
        .reset (reset),
        .load  (1'b1),
        .din   (in_valid && !stall),
        .dout  (out_valid)
    );

    register #(.WIDTH(64)) u_data_reg (
        .clk   (clk),
        .reset (reset),
        .load  (!stall),
        .din   (latch_d),
        .dout  (latch_q)
    );

    assign out_alu = latch_q[63:48];
    assign out_mdr = latch_q[47:32];
    assign out_ir  = latch_q[31:16];
    assign out_pc  = latch_q[15:0];

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, hand sequences, randomized run vs model.
module tb_mem_access_stage;

    localparam int GAP = 1;

    logic        clk, reset, in_valid;
    logic [15:0] in_alu, in_sr, in_ir, in_pc;
    logic        stall, mem_read, mem_write, mem_resp;
    logic [15:0] mem_address, mem_wdata, mem_rdata;
    logic [1:0]  mem_byte_enable;
    logic        out_valid;
    logic [15:0] out_alu, out_mdr, out_ir, out_pc;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem  [32768];
    logic [15:0] mmem [32768];

    typedef struct {
        int              cycles;
        int              idle;
        int              nacc;
        int              unstable;
        logic [1:0][15:0] addr;
        logic [1:0]      wr;
        logic [1:0][1:0] be;
        logic [1:0][15:0] wd;
        logic            ov;
        logic [15:0]     oalu, omdr, oir, opc;
    } obs_t;

    typedef struct {
        int              cycles;
        int              idle;
        int              nacc;
        logic [1:0][15:0] addr;
        logic [1:0]      wr;
        logic [1:0][1:0] be;
        logic [1:0][15:0] wd;
        logic [15:0]     mdr;
    } exp_t;

    typedef struct {
        logic [15:0] ir, alu, sr, pc;
        logic        pre_en;
        logic [15:0] pre_addr, pre_data;
        int          lat, cyc, nacc;
        logic [15:0] addr;
        logic        wr;
        logic [1:0]  be;
        logic [15:0] wd, mdr;
    } vec_t;

    mem_access_stage #(.WIDTH(16), .IND_GAP(GAP)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_alu          (in_alu),
        .in_sr           (in_sr),
        .in_ir           (in_ir),
        .in_pc           (in_pc),
        .stall           (stall),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .out_valid       (out_valid),
        .out_alu         (out_alu),
        .out_mdr         (out_mdr),
        .out_ir          (out_ir),
        .out_pc          (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents one instruction, acts as memory (response after lat cycles), records what happens.
    task automatic run_instr(input logic v, input logic [15:0] ir, alu, sr, pc,
                             input int lat1, input int lat2, input logic spur, output obs_t o);
        int   k, wn;
        logic done;
        o = '{default: 0};
        k = 0;
        wn = 0;
        done = 1'b0;
        in_valid = v;
        in_ir = ir;
        in_alu = alu;
        in_sr = sr;
        in_pc = pc;
        for (int c = 0; c < 60 && !done; c++) begin
            #1;
            o.cycles++;
            if (mem_read || mem_write) begin
                if (k < 2) begin
                    if (wn == 0) begin
                        o.addr[k] = mem_address;
                        o.wr[k]   = mem_write;
                        o.be[k]   = mem_byte_enable;
                        o.wd[k]   = mem_wdata;
                    end else if (o.addr[k] !== mem_address || o.wr[k] !== mem_write) begin
                        o.unstable++;
                    end
                end
                wn++;
                if (wn >= ((k == 0) ? lat1 : lat2)) begin
                    mem_resp = 1'b1;
                    if (mem_read) begin
                        mem_rdata = mem[mem_address[15:1]];
                    end else begin
                        if (mem_byte_enable[0]) mem[mem_address[15:1]][7:0] = mem_wdata[7:0];
                        if (mem_byte_enable[1]) mem[mem_address[15:1]][15:8] = mem_wdata[15:8];
                    end
                    k++;
                    wn = 0;
                end
            end else begin
                o.idle++;
                if (spur) begin
                    mem_resp = 1'b1;
                    mem_rdata = 16'hDEAD;
                end
            end
            #1;
            if (!stall) done = 1'b1;
            @(posedge clk);
            #1;
            mem_resp = 1'b0;
            mem_rdata = 16'($urandom);
        end
        o.nacc = k;
        o.ov   = out_valid;
        o.oalu = out_alu;
        o.omdr = out_mdr;
        o.oir  = out_ir;
        o.opc  = out_pc;
        in_valid = 1'b0;
    endtask

    task automatic compare(input string t, input obs_t o, input exp_t e, input logic v,
                           input logic [15:0] ir, alu, pc);
        chk({t, ".cycles"}, o.cycles, e.cycles);
        chk({t, ".idle"}, o.idle, e.idle);
        chk({t, ".nacc"}, o.nacc, e.nacc);
        chk({t, ".unstable"}, o.unstable, 0);
        for (int k = 0; k < 2; k++) begin
            if (k < e.nacc) begin
                chk({t, ".addr"}, o.addr[k], e.addr[k]);
                chk({t, ".wr"}, o.wr[k], e.wr[k]);
                if (e.wr[k]) begin
                    chk({t, ".be"}, o.be[k], e.be[k]);
                    chk({t, ".wdata"}, o.wd[k], e.wd[k]);
                end
            end
        end
        chk({t, ".out_valid"}, o.ov, v);
        chk({t, ".out_alu"}, o.oalu, alu);
        chk({t, ".out_mdr"}, o.omdr, e.mdr);
        chk({t, ".out_ir"}, o.oir, ir);
        chk({t, ".out_pc"}, o.opc, pc);
    endtask

    // Reference: what the instruction should do to memory and the latch, from the opcode rules.
    task automatic model(input logic v, input logic [15:0] ir, alu, sr,
                         input int lat1, input int lat2, output exp_t e);
        logic [3:0]  op;
        logic [15:0] w, ptr;
        logic [7:0]  b;
        logic        is_ld, is_st;
        e = '{default: 0};
        op = ir[15:12];
        is_ld = op inside {4'h6, 4'h2, 4'hA, 4'hF};
        is_st = op inside {4'h7, 4'h3, 4'hB};
        if (!v || !(is_ld || is_st)) begin
            e.cycles = 1;
            e.idle = 1;
            return;
        end
        e.addr[0] = {alu[15:1], 1'b0};
        e.nacc = 1;
        e.cycles = lat1;
        if (op == 4'hA || op == 4'hB) begin
            ptr = mmem[alu[15:1]];
            e.nacc = 2;
            e.addr[1] = {ptr[15:1], 1'b0};
            e.cycles = lat1 + GAP + lat2;
            e.idle = GAP;
            if (op == 4'hA) begin
                e.mdr = mmem[ptr[15:1]];
            end else begin
                e.wr[1] = 1'b1;
                e.be[1] = 2'b11;
                e.wd[1] = sr;
                mmem[ptr[15:1]] = sr;
            end
        end else if (is_ld) begin
            w = mmem[alu[15:1]];
            if (op == 4'h2) begin
                b = alu[0] ? w[15:8] : w[7:0];
                e.mdr = {{8{b[7]}}, b};
            end else begin
                e.mdr = w;
            end
        end else begin
            e.wr[0] = 1'b1;
            if (op == 4'h3) begin
                e.be[0] = alu[0] ? 2'b10 : 2'b01;
                e.wd[0] = {sr[7:0], sr[7:0]};
                if (alu[0]) mmem[alu[15:1]][15:8] = sr[7:0];
                else mmem[alu[15:1]][7:0] = sr[7:0];
            end else begin
                e.be[0] = 2'b11;
                e.wd[0] = sr;
                mmem[alu[15:1]] = sr;
            end
        end
    endtask

    initial begin
        vec_t        tbl [9];
        obs_t        o;
        exp_t        e;
        logic [3:0]  nm [9];
        logic [3:0]  op;
        logic [15:0] ir, alu, sr;
        logic        v, spur;
        int          l1, l2, sel, nw, nmis;

        //          ir        alu       sr        pc        pre  paddr     pdata    lat cyc n  addr     wr be     wd        mdr
        tbl[0] = '{16'h1261, 16'h0042, 16'h0000, 16'h0100, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000};
        tbl[1] = '{16'h6245, 16'h3001, 16'h0000, 16'h0102, 1, 16'h3000, 16'hBEEF, 3, 3, 1, 16'h3000, 0, 2'b00, 16'h0000, 16'hBEEF};
        tbl[2] = '{16'h2245, 16'h2005, 16'h0000, 16'h0104, 1, 16'h2004, 16'h80FF, 2, 2, 1, 16'h2004, 0, 2'b00, 16'h0000, 16'hFF80};
        tbl[3] = '{16'h2245, 16'h2004, 16'h0000, 16'h0106, 0, 16'h0000, 16'h0000, 1, 1, 1, 16'h2004, 0, 2'b00, 16'h0000, 16'hFFFF};
        tbl[4] = '{16'h3245, 16'h1003, 16'h1234, 16'h0108, 0, 16'h0000, 16'h0000, 2, 2, 1, 16'h1002, 1, 2'b10, 16'h3434, 16'h0000};
        tbl[5] = '{16'h7245, 16'h1006, 16'hCAFE, 16'h010A, 0, 16'h0000, 16'h0000, 1, 1, 1, 16'h1006, 1, 2'b11, 16'hCAFE, 16'h0000};
        tbl[6] = '{16'hF025, 16'h0024, 16'h0000, 16'h010C, 1, 16'h0024, 16'h1234, 1, 1, 1, 16'h0024, 0, 2'b00, 16'h0000, 16'h1234};
        tbl[7] = '{16'h3245, 16'h1002, 16'h00AB, 16'h010E, 0, 16'h0000, 16'h0000, 1, 1, 1, 16'h1002, 1, 2'b01, 16'hABAB, 16'h0000};
        tbl[8] = '{16'h6245, 16'h1002, 16'h0000, 16'h0110, 0, 16'h0000, 16'h0000, 2, 2, 1, 16'h1002, 0, 2'b00, 16'h0000, 16'h34AB};

        nm[0] = 4'h0; nm[1] = 4'h1; nm[2] = 4'h4; nm[3] = 4'h5; nm[4] = 4'h8;
        nm[5] = 4'h9; nm[6] = 4'hC; nm[7] = 4'hD; nm[8] = 4'hE;

        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;

        reset = 1'b1;
        in_valid = 1'b0;
        in_alu = 16'h0;
        in_sr = 16'h0;
        in_ir = 16'h0;
        in_pc = 16'h0;
        mem_resp = 1'b0;
        mem_rdata = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.out_valid", out_valid, 0);
        chk("reset.out_alu", out_alu, 0);
        chk("reset.out_mdr", out_mdr, 0);
        chk("reset.out_ir", out_ir, 0);
        chk("reset.out_pc", out_pc, 0);
        chk("reset.req", {mem_read, mem_write}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].pre_en) mem[tbl[i].pre_addr[15:1]] = tbl[i].pre_data;
            run_instr(1'b1, tbl[i].ir, tbl[i].alu, tbl[i].sr, tbl[i].pc, tbl[i].lat, 1, 1'b0, o);
            e = '{default: 0};
            e.cycles = tbl[i].cyc;
            e.idle = (tbl[i].nacc == 0) ? 1 : 0;
            e.nacc = tbl[i].nacc;
            e.addr[0] = tbl[i].addr;
            e.wr[0] = tbl[i].wr;
            e.be[0] = tbl[i].be;
            e.wd[0] = tbl[i].wd;
            e.mdr = tbl[i].mdr;
            compare($sformatf("vec%0d", i), o, e, 1'b1, tbl[i].ir, tbl[i].alu, tbl[i].pc);
        end

        // LDI with a spurious response during the idle gap
        mem[16'h4000 >> 1] = 16'h5000;
        mem[16'h5000 >> 1] = 16'h00AA;
        run_instr(1'b1, 16'hA245, 16'h4000, 16'h0000, 16'h0200, 2, 1, 1'b1, o);
        e = '{default: 0};
        e.cycles = 2 + GAP + 1;
        e.idle = GAP;
        e.nacc = 2;
        e.addr[0] = 16'h4000;
        e.addr[1] = 16'h5000;
        e.mdr = 16'h00AA;
        compare("ldi", o, e, 1'b1, 16'hA245, 16'h4000, 16'h0200);

        // STI aborted by reset while in the gap cycle
        mem[16'h0200 >> 1] = 16'h0300;
        mem[16'h0300 >> 1] = 16'h1111;
        in_valid = 1'b1;
        in_ir = 16'hB245;
        in_alu = 16'h0200;
        in_sr = 16'h5555;
        in_pc = 16'h0777;
        #1;
        chk("sti.req0", {mem_read, mem_write, mem_address}, {2'b10, 16'h0200});
        mem_resp = 1'b1;
        mem_rdata = 16'h0300;
        #1;
        chk("sti.stall0", stall, 1);
        @(posedge clk);
        #1;
        mem_resp = 1'b0;
        #1;
        chk("sti.gap_req", {mem_read, mem_write}, 0);
        chk("sti.gap_stall", stall, 1);
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst.req", {mem_read, mem_write}, 0);
        chk("rst.out_valid", out_valid, 0);
        nw = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (mem_write || mem_read) nw++;
        end
        chk("rst.no_req_after", nw, 0);
        chk("rst.ptr_untouched", mem[16'h0300 >> 1], 16'h1111);
        run_instr(1'b1, 16'h1261, 16'h0099, 16'h0000, 16'h0300, 1, 1, 1'b0, o);
        e = '{default: 0};
        e.cycles = 1;
        e.idle = 1;
        compare("post_rst", o, e, 1'b1, 16'h1261, 16'h0099, 16'h0300);

        // Randomized run against the model; pointer words start inside the working window.
        for (int i = 0; i < 32768; i++) begin
            mem[i] = (i >= 16'h0080 && i < 16'h00A0) ? 16'h0100 + 16'($urandom_range(0, 63))
                                                   : 16'($urandom);
            mmem[i] = mem[i];
        end
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0: op = 4'h6;
                1: op = 4'h2;
                2: op = 4'hA;
                3: op = 4'hF;
                4: op = 4'h7;
                5: op = 4'h3;
                6: op = 4'hB;
                default: op = nm[$urandom_range(0, 8)];
            endcase
            ir = {op, 12'($urandom)};
            alu = (sel == 7) ? 16'($urandom) : 16'h0100 + 16'($urandom_range(0, 63));
            sr = 16'($urandom);
            v = ($urandom_range(0, 9) != 0);
            spur = ($urandom_range(0, 3) == 0);
            l1 = $urandom_range(1, 3);
            l2 = $urandom_range(1, 3);
            model(v, ir, alu, sr, l1, l2, e);
            run_instr(v, ir, alu, sr, 16'(n), l1, l2, spur, o);
            compare($sformatf("rnd%0d", n), o, e, v, ir, alu, 16'(n));
        end
        nmis = 0;
        for (int i = 0; i < 32768; i++) if (mem[i] !== mmem[i]) nmis++;
        chk("rnd.memory", nmis, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
